// File: rtl/agc_fetch.sv
// AGC instruction fetch stage: program counter, bank address translation,
// a single outstanding req/gnt/rvalid memory read and a small output FIFO.
module agc_fetch #(
  parameter logic [11:0] RESET_PC   = 12'o4000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clock,
  input  logic        rst_l,
  input  logic [4:0]  fb_bank,
  input  logic [2:0]  eb_bank,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [11:0] redirect_pc,
  output logic        mem_req,
  output logic        mem_fixed,
  output logic [14:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [14:0] mem_rdata,
  output logic        instr_valid,
  output logic [14:0] instr,
  output logic [11:0] instr_pc,
  input  logic        instr_ready
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t         state, state_nxt;
  logic [11:0]    pc;
  logic           xlat_fixed;
  logic [14:0]    xlat_addr;
  logic           in_flight;
  logic           issue;
  logic           push;
  logic           pop;

  logic [CW-1:0]  count;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [26:0]    fifo_mem [FIFO_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (int'(p) == FIFO_DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign in_flight   = (state == REQ) || (state == WAIT);
  assign issue       = (state == IDLE) && !halt && !redirect_valid &&
                       ((int'(count) + int'(in_flight)) < FIFO_DEPTH);
  assign pop         = instr_valid && instr_ready;
  assign mem_req     = (state == REQ);
  assign instr_valid = (count != '0);
  assign instr       = fifo_mem[rd_ptr][26:12];
  assign instr_pc    = fifo_mem[rd_ptr][11:0];

  // Z address to physical word: low erasable, switched erasable (EB),
  // switched fixed (FB) and the two fixed-fixed banks 2 and 3.
  always_comb begin
    xlat_fixed = 1'b1;
    xlat_addr  = '0;
    case (pc[11:10])
      2'b00: begin
        xlat_fixed = 1'b0;
        if (pc[9:8] == 2'b11) xlat_addr = {4'b0, eb_bank, pc[7:0]};
        else                  xlat_addr = {5'b0, pc[9:8], pc[7:0]};
      end
      2'b01:   xlat_addr = {fb_bank, pc[9:0]};
      2'b10:   xlat_addr = {5'd2, pc[9:0]};
      default: xlat_addr = {5'd3, pc[9:0]};
    endcase
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    case (state)
      IDLE: if (issue) state_nxt = REQ;
      REQ: begin
        if (redirect_valid) state_nxt = mem_gnt ? DROP : IDLE;
        else if (mem_gnt)   state_nxt = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_nxt = IDLE;
          push      = !redirect_valid;
        end else if (redirect_valid) begin
          state_nxt = DROP;
        end
      end
      DROP: if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The address is captured on issue so later bank writes cannot disturb it.
  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      mem_fixed <= 1'b0;
      mem_addr  <= '0;
    end else begin
      state <= state_nxt;
      if (redirect_valid) pc <= redirect_pc;
      else if (push)      pc <= pc + 12'd1;
      if (issue) begin
        mem_fixed <= xlat_fixed;
        mem_addr  <= xlat_addr;
      end
    end
  end

  always_ff @(posedge clock or negedge rst_l) begin
    if (!rst_l) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
    end else if (redirect_valid) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {mem_rdata, pc};
        wr_ptr           <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_agc_fetch.sv
// Directed bench for agc_fetch: translation vector table plus hand-written
// fetch, backpressure, redirect, wrap, reset and halt sequences.
module tb_agc_fetch;

  logic        clock;
  logic        rst_l;
  logic [4:0]  fb_bank;
  logic [2:0]  eb_bank;
  logic        halt;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        mem_req;
  logic        mem_fixed;
  logic [14:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [14:0] mem_rdata;
  logic        instr_valid;
  logic [14:0] instr;
  logic [11:0] instr_pc;
  logic        instr_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [11:0] pc;
    logic [4:0]  fb;
    logic [2:0]  eb;
    logic        fixed;
    logic [14:0] addr;
  } vec_t;

  vec_t vecs [10];

  agc_fetch dut (
    .clock          (clock),
    .rst_l          (rst_l),
    .fb_bank        (fb_bank),
    .eb_bank        (eb_bank),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req        (mem_req),
    .mem_fixed      (mem_fixed),
    .mem_addr       (mem_addr),
    .mem_gnt        (mem_gnt),
    .mem_rvalid     (mem_rvalid),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive one cycle of pulse inputs, clock it in, then clear the pulses.
  task automatic applyStimulus(input logic rv, input logic [11:0] rpc,
                               input logic g, input logic rvd,
                               input logic [14:0] rd);
    redirect_valid = rv;
    redirect_pc    = rpc;
    mem_gnt        = g;
    mem_rvalid     = rvd;
    mem_rdata      = rd;
    tick();
    redirect_valid = 1'b0;
    mem_gnt        = 1'b0;
    mem_rvalid     = 1'b0;
    mem_rdata      = '0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0o required=%0o", name, actual, expected);
    end
  endtask

  task automatic step();
    applyStimulus(1'b0, 12'o0, 1'b0, 1'b0, 15'o0);
  endtask

  task automatic check_req(input string name, input logic fixed, input logic [14:0] addr);
    checkOutput({name, "_req"}, 32'(mem_req), 32'(1));
    checkOutput({name, "_fixed"}, 32'(mem_fixed), 32'(fixed));
    checkOutput({name, "_addr"}, 32'(mem_addr), 32'(addr));
  endtask

  task automatic check_all_zero(input string name);
    checkOutput({name, "_req"}, 32'(mem_req), 32'(0));
    checkOutput({name, "_fixed"}, 32'(mem_fixed), 32'(0));
    checkOutput({name, "_addr"}, 32'(mem_addr), 32'(0));
    checkOutput({name, "_valid"}, 32'(instr_valid), 32'(0));
    checkOutput({name, "_instr"}, 32'(instr), 32'(0));
    checkOutput({name, "_ipc"}, 32'(instr_pc), 32'(0));
  endtask

  initial begin
    vecs[0] = '{12'o4000, 5'd4,  3'd0, 1'b1, {5'd2, 10'o0000}};
    vecs[1] = '{12'o4000, 5'd31, 3'd7, 1'b1, {5'd2, 10'o0000}};
    vecs[2] = '{12'o2345, 5'd27, 3'd0, 1'b1, {5'd27, 10'o0345}};
    vecs[3] = '{12'o1500, 5'd0,  3'd6, 1'b0, {4'b0, 3'd6, 8'o100}};
    vecs[4] = '{12'o0400, 5'd9,  3'd5, 1'b0, {4'b0, 3'd1, 8'o000}};
    vecs[5] = '{12'o7777, 5'd1,  3'd1, 1'b1, {5'd3, 10'o1777}};
    vecs[6] = '{12'o0000, 5'd3,  3'd3, 1'b0, 15'o0};
    vecs[7] = '{12'o0123, 5'd0,  3'd5, 1'b0, {4'b0, 3'd0, 8'o123}};
    vecs[8] = '{12'o1377, 5'd0,  3'd2, 1'b0, {4'b0, 3'd2, 8'o377}};
    vecs[9] = '{12'o6000, 5'd17, 3'd0, 1'b1, {5'd3, 10'o0000}};

    rst_l = 1'b0; halt = 1'b0; fb_bank = 5'd4; eb_bank = 3'd0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    check_all_zero("reset");
    rst_l = 1'b1;

    // First fetch at GOJAM entry with minimum latency.
    step();
    check_req("first", 1'b1, {5'd2, 10'o0000});
    checkOutput("first_valid", 32'(instr_valid), 32'(0));
    applyStimulus(1'b0, 12'o0, 1'b1, 1'b0, 15'o0);
    checkOutput("t2_req", 32'(mem_req), 32'(0));
    checkOutput("t2_valid", 32'(instr_valid), 32'(0));
    applyStimulus(1'b0, 12'o0, 1'b0, 1'b1, 15'o12345);
    checkOutput("t3_valid", 32'(instr_valid), 32'(1));
    checkOutput("t3_instr", 32'(instr), 32'(15'o12345));
    checkOutput("t3_ipc", 32'(instr_pc), 32'(12'o4000));
    step();
    check_req("second", 1'b1, {5'd2, 10'o0001});

    // Backpressure: two words fill the buffer and issue stops.
    applyStimulus(1'b0, 12'o0, 1'b1, 1'b0, 15'o0);
    applyStimulus(1'b0, 12'o0, 1'b0, 1'b1, 15'o23456);
    checkOutput("full_head", 32'(instr), 32'(15'o12345));
    step(); step();
    checkOutput("full_noreq", 32'(mem_req), 32'(0));
    checkOutput("full_valid", 32'(instr_valid), 32'(1));
    instr_ready = 1'b1;
    step();
    checkOutput("pop1_instr", 32'(instr), 32'(15'o23456));
    checkOutput("pop1_ipc", 32'(instr_pc), 32'(12'o4001));
    checkOutput("pop1_noreq", 32'(mem_req), 32'(0));
    step();
    instr_ready = 1'b0;
    checkOutput("pop2_valid", 32'(instr_valid), 32'(0));
    check_req("resume", 1'b1, {5'd2, 10'o0002});

    // Redirect while waiting: late data dropped, fetch restarts at target.
    applyStimulus(1'b0, 12'o0, 1'b1, 1'b0, 15'o0);
    applyStimulus(1'b1, 12'o3000, 1'b0, 1'b0, 15'o0);
    checkOutput("drop_req", 32'(mem_req), 32'(0));
    applyStimulus(1'b0, 12'o0, 1'b0, 1'b1, 15'o07070);
    checkOutput("drop_valid", 32'(instr_valid), 32'(0));
    step();
    check_req("tgt", 1'b1, {5'd4, 10'o1000});
    applyStimulus(1'b0, 12'o0, 1'b1, 1'b0, 15'o0);
    applyStimulus(1'b0, 12'o0, 1'b0, 1'b1, 15'o00777);
    checkOutput("tgt_valid", 32'(instr_valid), 32'(1));
    checkOutput("tgt_ipc", 32'(instr_pc), 32'(12'o3000));
    checkOutput("tgt_instr", 32'(instr), 32'(15'o00777));

    // Redirect coinciding with rvalid: word discarded, buffer flushed.
    step();
    applyStimulus(1'b0, 12'o0, 1'b1, 1'b0, 15'o0);
    applyStimulus(1'b1, 12'o7777, 1'b0, 1'b1, 15'o05555);
    checkOutput("flush_valid", 32'(instr_valid), 32'(0));
    step();
    check_req("top", 1'b1, {5'd3, 10'o1777});
    applyStimulus(1'b0, 12'o0, 1'b1, 1'b0, 15'o0);
    applyStimulus(1'b0, 12'o0, 1'b0, 1'b1, 15'o01111);
    checkOutput("top_ipc", 32'(instr_pc), 32'(12'o7777));
    step();
    check_req("wrap", 1'b0, 15'o0);

    // Redirect with grant in REQ (and a simultaneous pop) goes via DROP.
    instr_ready = 1'b1;
    applyStimulus(1'b1, 12'o4000, 1'b1, 1'b0, 15'o0);
    instr_ready = 1'b0;
    checkOutput("rg_req", 32'(mem_req), 32'(0));
    checkOutput("rg_valid", 32'(instr_valid), 32'(0));
    applyStimulus(1'b0, 12'o0, 1'b0, 1'b1, 15'o03333);
    checkOutput("rg_drop_valid", 32'(instr_valid), 32'(0));
    step();
    check_req("rg_next", 1'b1, {5'd2, 10'o0000});
    applyStimulus(1'b1, 12'o0400, 1'b0, 1'b0, 15'o0);
    checkOutput("withdraw_req", 32'(mem_req), 32'(0));
    step();
    check_req("withdraw_next", 1'b0, {4'b0, 3'd1, 8'o000});

    // Asynchronous reset in the middle of WAIT.
    applyStimulus(1'b0, 12'o0, 1'b1, 1'b0, 15'o0);
    #2;
    rst_l = 1'b0;
    #1;
    check_all_zero("midreset");
    halt = 1'b1;
    tick();
    rst_l = 1'b1;
    step();
    halt = 1'b0;
    step();
    check_req("after_reset", 1'b1, {5'd2, 10'o0000});

    // Halt lets the outstanding read finish and the buffer drain.
    halt = 1'b1;
    applyStimulus(1'b0, 12'o0, 1'b1, 1'b0, 15'o0);
    applyStimulus(1'b0, 12'o0, 1'b0, 1'b1, 15'o04444);
    checkOutput("halt_valid", 32'(instr_valid), 32'(1));
    checkOutput("halt_instr", 32'(instr), 32'(15'o04444));
    checkOutput("halt_ipc", 32'(instr_pc), 32'(12'o4000));
    step();
    checkOutput("halt_noreq", 32'(mem_req), 32'(0));
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    checkOutput("halt_drain", 32'(instr_valid), 32'(0));
    checkOutput("halt_noreq2", 32'(mem_req), 32'(0));
    applyStimulus(1'b0, 12'o0, 1'b0, 1'b1, 15'o06666);
    checkOutput("stray_rvalid", 32'(instr_valid), 32'(0));

    // Translation table; bank writes after issue must not move the address.
    for (int i = 0; i < 10; i++) begin
      fb_bank = vecs[i].fb;
      eb_bank = vecs[i].eb;
      applyStimulus(1'b1, vecs[i].pc, 1'b0, 1'b0, 15'o0);
      halt = 1'b0;
      step();
      check_req($sformatf("vec%0d", i), vecs[i].fixed, vecs[i].addr);
      fb_bank = ~vecs[i].fb;
      eb_bank = ~vecs[i].eb;
      halt = 1'b1;
      step();
      check_req($sformatf("vec%0d_hold", i), vecs[i].fixed, vecs[i].addr);
      applyStimulus(1'b1, vecs[i].pc, 1'b0, 1'b0, 15'o0);
      checkOutput($sformatf("vec%0d_withdraw", i), 32'(mem_req), 32'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/agc_fetch.md
Name: agc_fetch

Overview:
Instruction fetch stage directly upstream of the decoder. Holds the 12-bit program counter (Z) and translates it through the fixed/erasable bank registers into a physical memory address. Issues one memory read at a time over a req/gnt/rvalid handshake and buffers returned words in a small FIFO. Presents them to the decoder over a valid/ready interface, with branch redirect, flush and halt.

Parameters:
RESET_PC, 12'o4000, PC value loaded at reset (GOJAM entry).
FIFO_DEPTH, 2, output buffer entries; power of two, at least 1.

Ports:
clock  in  1  system clock.
rst_l  in  1  asynchronous active-low reset.
fb_bank  in  5  fixed bank register FB.
eb_bank  in  3  erasable bank register EB.
halt  in  1  level; blocks new memory requests.
redirect_valid  in  1  branch taken, one-cycle pulse.
redirect_pc  in  12  branch target.
mem_req  out  1  read request.
mem_fixed  out  1  1 = fixed (ROM) space, 0 = erasable.
mem_addr  out  15  physical word address.
mem_gnt  in  1  request accepted this cycle.
mem_rvalid  in  1  read data valid.
mem_rdata  in  15  read data.
instr_valid  out  1  FIFO head valid.
instr  out  15  FIFO head instruction word.
instr_pc  out  12  Z address of the head word.
instr_ready  in  1  decoder accepts head.

Behaviour:
- Reset (asynchronous, rst_l=0): pc=RESET_PC; state=IDLE; FIFO empty. mem_req, mem_fixed, mem_addr, instr_valid, instr, instr_pc are all 0.
- Address translation, evaluated when IDLE transitions to REQ; mem_fixed and mem_addr are registered and held stable until grant:
  - pc[11:10]=00 → erasable. If pc[9:8]=11, addr={4'b0,eb_bank,pc[7:0]}. Otherwise addr={4'b0,1'b0,pc[9:8],pc[7:0]}. mem_fixed=0.
  - pc[11:10]=01 → addr={fb_bank,pc[9:0]}, fixed.
  - pc[11:10]=10 → addr={5'd2,pc[9:0]}, fixed.
  - pc[11:10]=11 → addr={5'd3,pc[9:0]}, fixed.
  - Bank changes after issue do not affect the in-flight request.
- Credit rule: issue only if fifo_count + in_flight < FIFO_DEPTH, and halt=0, and redirect_valid=0.
- FSM:
  - IDLE: credit ok → REQ (address registered).
  - REQ: mem_req=1. On mem_gnt → WAIT. On redirect_valid without gnt → request withdrawn (mem_req=0 next cycle), → IDLE. On redirect_valid with gnt in the same cycle → DROP.
  - WAIT: on mem_rvalid, push {mem_rdata, pc}, pc←pc+1, → IDLE. On redirect_valid → DROP, unless mem_rvalid is in the same cycle; then the data is discarded and the next state is IDLE.
  - DROP: on mem_rvalid, discard → IDLE. Further redirects in DROP only update pc.
- Redirect in any state: pc←redirect_pc and FIFO flushed; instr_valid=0 the next cycle. If instr_ready&&instr_valid occurs in the same cycle, that head counts as consumed; the flush covers the rest.
- pc increments modulo 2^12: 12'o7777+1 → 0.
- FIFO: push on accepted rvalid; pop on instr_valid&&instr_ready. Simultaneous push and pop while full is legal. The pushed entry becomes visible the cycle after rvalid.
- Minimum latency, empty FIFO and gnt in the REQ cycle with rvalid one cycle later: IDLE(t0), REQ/gnt(t1), rvalid(t2), instr_valid(t3).
- Halt: stops new issue only. The outstanding request completes normally and the FIFO keeps draining.
- A mem_rvalid arriving in IDLE or REQ is a protocol error and is ignored.

Test Plan:
- Reset release, fb=5'd4, gnt immediate, rvalid next cycle → first request has mem_fixed=1, mem_addr={5'd2,10'o0000}. instr_pc=12'o4000 with instr=mem_rdata at t3; next request addr for pc=12'o4001.
- pc=12'o2345, fb=5'd27 → mem_addr={5'd27,10'o0345}. pc=12'o1500, eb=3'd6 → mem_fixed=0, mem_addr={4'b0,3'd6,8'o100}. pc=12'o0400 → {4'b0,3'd1,8'o000}.
- instr_ready=0 → exactly 2 words buffered, mem_req stays 0. Then instr_ready=1 → words popped in order, fetching resumes.
- redirect_valid to 12'o3000 while in WAIT → late rvalid discarded, FIFO flushed. The next valid instr carries instr_pc=12'o3000.
- redirect_valid in the same cycle as rvalid in WAIT → word not pushed. Redirect in REQ without gnt → mem_req drops the next cycle.
- pc=12'o7777 fetched → next fetch pc=0 (erasable addr 0). Assert rst_l=0 mid-WAIT → all outputs 0 immediately, pc=12'o4000 after release.
